// File: rtl/rvlab_jtag_tap.sv
// rvlab_jtag_tap: JTAG TAP with RISC-V DTM, every JTAG pin oversampled on clk_i.
// Define RVLAB_JTAG_TAP_DMI_EN to enable the DMI register and the DMI ports.
//
// DMI handshakes: a transfer happens on a clk_i edge where valid and ready are
// both 1; valid holds with a stable payload until then, and ready may be anything.
module rvlab_jtag_tap #(
  parameter logic [31:0] IDCODE      = 32'h1BEE_F001,
  parameter int unsigned ABITS       = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             jtag_tck_i,
  input  logic             jtag_tms_i,
  input  logic             jtag_tdi_i,
  input  logic             jtag_trst_ni,
  output logic             jtag_tdo_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  output logic [ABITS-1:0] dmi_req_addr_o,
  output logic [31:0]      dmi_req_data_o,
  output logic [1:0]       dmi_req_op_o,
  input  logic             dmi_rsp_valid_i,
  output logic             dmi_rsp_ready_o,
  input  logic [31:0]      dmi_rsp_data_i,
  input  logic [1:0]       dmi_rsp_resp_i
);
  localparam int unsigned DRW = ABITS + 34;
  localparam int unsigned SW  = $clog2(DRW);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {DR_BYPASS, DR_IDCODE, DR_DTMCS, DR_DMI} dr_sel_e;

  logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trst_sync_q;
  logic                   tck_prev_q;
  logic                   tck_s, tms_s, tdi_s, trst_s, tck_rise, tck_fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tck_sync_q  <= '0;
      tms_sync_q  <= '1;
      tdi_sync_q  <= '0;
      trst_sync_q <= '0;
      tck_prev_q  <= 1'b0;
    end else begin
      tck_sync_q  <= SYNC_STAGES'({tck_sync_q, jtag_tck_i});
      tms_sync_q  <= SYNC_STAGES'({tms_sync_q, jtag_tms_i});
      tdi_sync_q  <= SYNC_STAGES'({tdi_sync_q, jtag_tdi_i});
      trst_sync_q <= SYNC_STAGES'({trst_sync_q, jtag_trst_ni});
      tck_prev_q  <= tck_s;
    end
  end

  assign tck_s    = tck_sync_q[SYNC_STAGES-1];
  assign tms_s    = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
  assign trst_s   = trst_sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev_q;
  assign tck_fall = ~tck_s & tck_prev_q;

  tap_state_e     state_q, state_d, state_nxt;
  logic [4:0]     ir_q, ir_d;
  logic [DRW-1:0] sr_q, sr_d, sr_shifted, dmi_cap;
  logic           tdo_q, tdo_d;
  dr_sel_e        dr_sel;
  logic [SW-1:0]  shift_msb;
  logic [31:0]    dtmcs_cap;
  logic [1:0]     dmistat;
  logic [5:0]     abits_rep;

  always_comb begin
    case (ir_q)
      5'h01:   dr_sel = DR_IDCODE;
      5'h10:   dr_sel = DR_DTMCS;
`ifdef RVLAB_JTAG_TAP_DMI_EN
      5'h11:   dr_sel = DR_DMI;
`endif
      default: dr_sel = DR_BYPASS;
    endcase
  end

  assign dtmcs_cap = {14'b0, 2'b0, 1'b0, 3'd1, dmistat, abits_rep, 4'd1};

  // The shared shift register takes TDI at the MSB of the active length only.
  always_comb begin
    shift_msb = '0;
    if (state_q == SHIFT_IR) begin
      shift_msb = SW'(4);
    end else begin
      case (dr_sel)
        DR_IDCODE, DR_DTMCS: shift_msb = SW'(31);
        DR_DMI:              shift_msb = SW'(DRW - 1);
        default:             shift_msb = '0;
      endcase
    end
    sr_shifted            = {1'b0, sr_q[DRW-1:1]};
    sr_shifted[shift_msb] = tdi_s;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      TLR:      state_nxt = tms_s ? TLR      : RTI;
      RTI:      state_nxt = tms_s ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = tms_s ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = tms_s ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_nxt = tms_s ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_nxt = tms_s ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = tms_s ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_nxt = tms_s ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_nxt = tms_s ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = tms_s ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = tms_s ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_nxt = tms_s ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_nxt = tms_s ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = tms_s ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_nxt = tms_s ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_nxt = tms_s ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    sr_d    = sr_q;
    tdo_d   = tdo_q;
    if (!trst_s) begin
      state_d = TLR;
      ir_d    = 5'h01;
    end else begin
      if (state_q == TLR) ir_d = 5'h01;
      if (tck_rise) begin
        state_d = state_nxt;
        case (state_q)
          CAP_IR:             sr_d = DRW'(5'b00001);
          SHIFT_IR, SHIFT_DR: sr_d = sr_shifted;
          UPD_IR:             ir_d = sr_q[4:0];
          CAP_DR: begin
            case (dr_sel)
              DR_IDCODE: sr_d = DRW'(IDCODE);
              DR_DTMCS:  sr_d = DRW'(dtmcs_cap);
              DR_DMI:    sr_d = dmi_cap;
              default:   sr_d = '0;
            endcase
          end
          default: ;
        endcase
      end
      if (tck_fall) tdo_d = (state_q == SHIFT_IR || state_q == SHIFT_DR) ? sr_q[0] : 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TLR;
      ir_q    <= 5'h01;
      sr_q    <= '0;
      tdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      sr_q    <= sr_d;
      tdo_q   <= tdo_d;
    end
  end

  assign jtag_tdo_o = tdo_q;

`ifdef RVLAB_JTAG_TAP_DMI_EN
  logic             req_valid_q, req_valid_d, pending_q, pending_d, discard_q, discard_d;
  logic [ABITS-1:0] req_addr_q, req_addr_d;
  logic [31:0]      req_data_q, req_data_d, rsp_data_q, rsp_data_d;
  logic [1:0]       req_op_q, req_op_d, dmistat_q, dmistat_d;
  logic             rsp_ready, rsp_hs, cap_stb, upd_stb;

  assign cap_stb   = tck_rise & trst_s & (state_q == CAP_DR);
  assign upd_stb   = tck_rise & trst_s & (state_q == UPD_DR);
  // discard_q keeps the response channel open for the reply orphaned by dmihardreset.
  assign rsp_ready = (pending_q & ~req_valid_q) | discard_q;
  assign rsp_hs    = dmi_rsp_valid_i & rsp_ready;
  assign dmistat   = dmistat_q;
  assign abits_rep = 6'(ABITS);
  assign dmi_cap   = {req_addr_q, rsp_data_q, pending_q ? 2'd3 : dmistat_q};

  always_comb begin
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_op_d    = req_op_q;
    rsp_data_d  = rsp_data_q;
    dmistat_d   = dmistat_q;
    pending_d   = pending_q;
    discard_d   = discard_q;
    if (req_valid_q && dmi_req_ready_i) req_valid_d = 1'b0;
    if (rsp_hs) begin
      if (discard_q) begin
        discard_d = 1'b0;
      end else begin
        rsp_data_d = dmi_rsp_data_i;
        pending_d  = 1'b0;
        if (dmi_rsp_resp_i != 2'd0 && dmistat_q == 2'd0) dmistat_d = 2'd2;
      end
    end
    if (cap_stb && dr_sel == DR_DMI && pending_q) dmistat_d = 2'd3;
    if (upd_stb && dr_sel == DR_DTMCS) begin
      if (sr_q[16]) dmistat_d = 2'd0;
      if (sr_q[17]) begin
        dmistat_d   = 2'd0;
        pending_d   = 1'b0;
        req_valid_d = 1'b0;
        discard_d   = discard_q | (pending_q & ~req_valid_q & ~rsp_hs);
      end
    end
    if (upd_stb && dr_sel == DR_DMI && (sr_q[1:0] == 2'd1 || sr_q[1:0] == 2'd2)) begin
      if (!pending_q && dmistat_q == 2'd0) begin
        req_addr_d  = sr_q[DRW-1:34];
        req_data_d  = sr_q[33:2];
        req_op_d    = sr_q[1:0];
        req_valid_d = 1'b1;
        pending_d   = 1'b1;
      end else begin
        dmistat_d = 2'd3;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_op_q    <= '0;
      rsp_data_q  <= '0;
      dmistat_q   <= '0;
      pending_q   <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_op_q    <= req_op_d;
      rsp_data_q  <= rsp_data_d;
      dmistat_q   <= dmistat_d;
      pending_q   <= pending_d;
      discard_q   <= discard_d;
    end
  end

  assign dmi_req_valid_o = req_valid_q;
  assign dmi_req_addr_o  = req_addr_q;
  assign dmi_req_data_o  = req_data_q;
  assign dmi_req_op_o    = req_op_q;
  assign dmi_rsp_ready_o = rsp_ready;
`else
  logic unused_dmi;
  assign unused_dmi      = ^{dmi_req_ready_i, dmi_rsp_valid_i, dmi_rsp_data_i, dmi_rsp_resp_i};
  assign dmistat         = 2'd0;
  assign abits_rep       = 6'd0;
  assign dmi_cap         = '0;
  assign dmi_req_valid_o = 1'b0;
  assign dmi_req_addr_o  = '0;
  assign dmi_req_data_o  = '0;
  assign dmi_req_op_o    = '0;
  assign dmi_rsp_ready_o = 1'b1;
`endif
endmodule

// File: tb/tb_rvlab_jtag_tap.sv
// Self-checking bench for rvlab_jtag_tap: bit-banged JTAG master, simple DM
// responder and a register-level DTM model; follows RVLAB_JTAG_TAP_DMI_EN.
module tb_rvlab_jtag_tap;
  localparam int ABITS = 7;
  localparam int DRW   = ABITS + 34;
  localparam int HALF  = 6;
  localparam logic [31:0] IDC = 32'h1BEE_F001;
`ifdef RVLAB_JTAG_TAP_DMI_EN
  localparam bit DMI_EN = 1'b1;
`else
  localparam bit DMI_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic tck = 1'b0, tms = 1'b1, tdi = 1'b0, trst_n = 1'b1;
  logic req_ready = 1'b0, rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic [1:0]  rsp_resp = '0;
  logic jtag_tdo, dmi_req_valid, dmi_rsp_ready;
  logic [ABITS-1:0] dmi_req_addr;
  logic [31:0] dmi_req_data;
  logic [1:0]  dmi_req_op;

  always #5 clk = ~clk;

  rvlab_jtag_tap #(.IDCODE(IDC), .ABITS(ABITS), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .jtag_tck_i(tck), .jtag_tms_i(tms), .jtag_tdi_i(tdi), .jtag_trst_ni(trst_n),
    .jtag_tdo_o(jtag_tdo),
    .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(req_ready),
    .dmi_req_addr_o(dmi_req_addr), .dmi_req_data_o(dmi_req_data), .dmi_req_op_o(dmi_req_op),
    .dmi_rsp_valid_i(rsp_valid), .dmi_rsp_ready_o(dmi_rsp_ready),
    .dmi_rsp_data_i(rsp_data), .dmi_rsp_resp_i(rsp_resp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the DTM's architectural state.
  logic [1:0]       m_dmistat;
  logic             m_pending, m_discard;
  logic [ABITS-1:0] m_addr;
  logic [31:0]      m_rsp_data;

  task automatic m_reset();
    m_dmistat = 2'd0; m_pending = 1'b0; m_discard = 1'b0; m_addr = '0; m_rsp_data = '0;
  endtask

  function automatic logic [31:0] exp_dtmcs();
    return 32'h0000_1001 | (32'(m_dmistat) << 10) | ((DMI_EN ? 32'(ABITS) : 32'd0) << 4);
  endfunction

  task automatic m_capture(output logic [63:0] v);
    logic [1:0] st;
    st = m_pending ? 2'd3 : m_dmistat;
    v = (64'(m_addr) << 34) | (64'(m_rsp_data) << 2) | 64'(st);
    if (m_pending) m_dmistat = 2'd3;
  endtask

  task automatic m_dmi_update(input logic [ABITS-1:0] a, input logic [1:0] op, output logic issued);
    issued = 1'b0;
    if (op == 2'd1 || op == 2'd2) begin
      if (!m_pending && m_dmistat == 2'd0) begin
        issued = 1'b1; m_pending = 1'b1; m_addr = a;
      end else begin
        m_dmistat = 2'd3;
      end
    end
  endtask

  task automatic m_dtmcs_update(input logic [31:0] v);
    if (DMI_EN && v[16]) m_dmistat = 2'd0;
    if (DMI_EN && v[17]) begin
      m_dmistat = 2'd0; m_discard = m_pending; m_pending = 1'b0;
    end
  endtask

  // JTAG master: one TCK period; TDO is sampled just before the rise.
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
    tms = tms_v; tdi = tdi_v;
    repeat (HALF) @(negedge clk);
    tdo_v = jtag_tdo;
    tck = 1'b1;
    repeat (HALF) @(negedge clk);
    tck = 1'b0;
  endtask

  task automatic shift_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < len; i++) begin
      tck_cycle(i == len - 1, din[i], b);
      dout[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic shift_ir(input logic [4:0] v, output logic [4:0] cap);
    logic b;
    cap = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, v[i], b);
      cap[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic set_ir(input logic [4:0] v);
    logic [4:0] cap;
    shift_ir(v, cap);
    check("ir_capture", 64'(cap), 64'h01);
  endtask

  task automatic dtmcs_access(input logic [31:0] wr);
    logic [63:0] out;
    shift_dr(32, 64'(wr), out);
    check("dtmcs", out, 64'(exp_dtmcs()));
    m_dtmcs_update(wr);
  endtask

  task automatic dmi_access(input logic [ABITS-1:0] a, input logic [31:0] d, input logic [1:0] op);
    logic [63:0] out, exp;
    logic issued;
    m_capture(exp);
    shift_dr(DRW, 64'({a, d, op}), out);
    check("dmi_capture", out, exp);
    m_dmi_update(a, op, issued);
    check("req_valid", 64'(dmi_req_valid), 64'(issued));
    if (issued) check("req_payload", 64'({dmi_req_addr, dmi_req_data, dmi_req_op}), 64'({a, d, op}));
  endtask

  task automatic dm_accept();
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check("req_valid_drop", 64'(dmi_req_valid), 64'd0);
    check("rsp_ready_after_accept", 64'(dmi_rsp_ready), 64'(m_pending));
  endtask

  task automatic dm_respond(input logic [31:0] d, input logic [1:0] r);
    rsp_valid = 1'b1; rsp_data = d; rsp_resp = r;
    @(negedge clk);
    rsp_valid = 1'b0;
    if (m_discard) m_discard = 1'b0;
    else if (m_pending) begin
      m_rsp_data = d; m_pending = 1'b0;
      if (r != 2'd0 && m_dmistat == 2'd0) m_dmistat = 2'd2;
    end
  endtask

  initial begin
    logic [63:0] out;
    logic [7:0] pat;
    logic b;
    logic [ABITS-1:0] a;
    logic [31:0] d;
    logic [1:0] op;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_tdo", 64'(jtag_tdo), 64'd0);
    check("rst_req_valid", 64'(dmi_req_valid), 64'd0);
    check("rst_rsp_ready", 64'(dmi_rsp_ready), DMI_EN ? 64'd0 : 64'd1);
    check("rst_payload", 64'({dmi_req_addr, dmi_req_data, dmi_req_op}), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    trst_n = 1'b0;
    repeat (4) @(negedge clk);
    trst_n = 1'b1;
    repeat (4) @(negedge clk);
    tck_cycle(1'b0, 1'b0, b);
    shift_dr(32, 64'd0, out);
    check("idcode", out, 64'(IDC));
    check("tdo_idle", 64'(jtag_tdo), 64'd0);
    set_ir(5'h10);
    dtmcs_access(32'd0);

`ifdef RVLAB_JTAG_TAP_DMI_EN
    set_ir(5'h11);
    dmi_access(7'h10, 32'h1, 2'd2);
    repeat (5) begin
      @(negedge clk);
      check("req_hold", 64'({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}),
            64'({1'b1, 7'h10, 32'h1, 2'd2}));
    end
    dm_accept();
    dm_respond(32'h0, 2'd0);
    check("rsp_ready_drop", 64'(dmi_rsp_ready), 64'd0);
    dmi_access('0, '0, 2'd0);

    a = ABITS'($urandom);
    dmi_access(a, 32'h0, 2'd1);
    dm_accept();
    dmi_access('0, '0, 2'd0);
    set_ir(5'h10);
    dtmcs_access(32'h0001_0000);
    dm_respond($urandom, 2'd0);
    dtmcs_access(32'd0);
    set_ir(5'h11);
    dmi_access('0, '0, 2'd0);

    dmi_access(ABITS'($urandom), $urandom, 2'd2);
    dm_accept();
    dm_respond($urandom, 2'd2);
    dmi_access(ABITS'($urandom), $urandom, 2'd1);
    set_ir(5'h10);
    dtmcs_access(32'h0001_0000);

    set_ir(5'h11);
    dmi_access(ABITS'($urandom), 32'h0, 2'd1);
    dm_accept();
    set_ir(5'h10);
    dtmcs_access(32'h0002_0000);
    dm_respond($urandom, 2'd0);
    set_ir(5'h11);
    dmi_access('0, '0, 2'd0);

    for (int t = 0; t < 4; t++) begin
      a = ABITS'($urandom); d = $urandom; op = 2'($urandom_range(1, 2));
      dmi_access(a, d, op);
      repeat ($urandom_range(0, 4)) begin
        @(negedge clk);
        check("req_hold_rand", 64'({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}),
              64'({1'b1, a, d, op}));
      end
      dm_accept();
      repeat ($urandom_range(0, 4)) @(negedge clk);
      dm_respond($urandom, 2'd0);
    end
    dmi_access('0, '0, 2'd0);

    dmi_access(ABITS'($urandom), $urandom, 2'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_abort_valid", 64'(dmi_req_valid), 64'd0);
    @(negedge clk);
    check("rst_abort_payload", 64'({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}), 64'd0);
    m_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    tck_cycle(1'b0, 1'b0, b);
    set_ir(5'h10);
    dtmcs_access(32'd0);
    set_ir(5'h11);
    dmi_access('0, '0, 2'd0);
`else
    set_ir(5'h11);
    pat = 8'($urandom);
    shift_dr(9, 64'({1'b0, pat}), out);
    check("ir11_bypass", out, 64'({pat, 1'b0}));
    set_ir(5'h10);
    dtmcs_access(32'h0003_0000);
    dtmcs_access(32'd0);
    check("dis_outputs", 64'({dmi_req_valid, dmi_rsp_ready, dmi_req_addr, dmi_req_data, dmi_req_op}),
          64'({1'b0, 1'b1, 41'd0}));
`endif

    set_ir(5'h1F);
    shift_dr(9, 64'({1'b0, 8'hA5}), out);
    check("bypass_a5", out, 64'({8'hA5, 1'b0}));
    pat = 8'($urandom);
    shift_dr(9, 64'({1'b0, pat}), out);
    check("bypass_rand", out, 64'({pat, 1'b0}));

    set_ir(5'h10);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    repeat (5) tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    check("tdo_after_tlr", 64'(jtag_tdo), 64'd0);
    shift_dr(32, 64'd0, out);
    check("tlr_idcode", out, 64'(IDC));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
